// File: rtl/change_dispenser.sv
// Greedy change payout: splits an amount into 50/20/10/5/1 notes and requests
// them one at a time from the dispensing mechanism over a req/ack handshake.
module change_dispenser #(
  parameter int WIDTH       = 8,
  parameter int ACK_TIMEOUT = 50000,
  parameter int GAP         = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] change_amount,
  input  logic             abort,
  input  logic             dispense_ack,
  output logic             out_money_one,
  output logic             out_money_five,
  output logic             out_money_ten,
  output logic             out_money_twenty,
  output logic             out_money_fifty,
  output logic [WIDTH-1:0] remaining,
  output logic [7:0]       note_count,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_REQ    = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q;
  logic [4:0]       req_q;
  logic [4:0]       req_d;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] den_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] rem_d;
  logic [7:0]       note_q;
  logic [TW-1:0]    tmo_q;
  logic [GW-1:0]    gap_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;

  // Largest denomination not exceeding what is still owed (req bit order: 1,5,10,20,50).
  always_comb begin
    req_d = 5'b00001;
    den_d = WIDTH'(1);
    if (remaining_q >= WIDTH'(50)) begin
      req_d = 5'b10000;
      den_d = WIDTH'(50);
    end else if (remaining_q >= WIDTH'(20)) begin
      req_d = 5'b01000;
      den_d = WIDTH'(20);
    end else if (remaining_q >= WIDTH'(10)) begin
      req_d = 5'b00100;
      den_d = WIDTH'(10);
    end else if (remaining_q >= WIDTH'(5)) begin
      req_d = 5'b00010;
      den_d = WIDTH'(5);
    end else begin
      req_d = 5'b00001;
      den_d = WIDTH'(1);
    end
  end

  assign rem_d = remaining_q - den_q;

  // Payout sequencer; every output is a register updated here.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      req_q       <= 5'b00000;
      den_q       <= '0;
      remaining_q <= '0;
      note_q      <= 8'd0;
      tmo_q       <= '0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= change_amount;
            note_q      <= 8'd0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (change_amount == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            req_q   <= req_d;
            den_q   <= den_d;
            tmo_q   <= '0;
            state_q <= S_REQ;
          end
        end
        // Ack wins over a timeout landing on the same edge; abort waits for the note.
        S_REQ: begin
          if (dispense_ack) begin
            req_q       <= 5'b00000;
            remaining_q <= rem_d;
            if (note_q != 8'hFF) begin
              note_q <= note_q + 8'd1;
            end
            if (rem_d == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end else if (tmo_q == TMO_LAST) begin
            req_q   <= 5'b00000;
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        S_GAP: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_SELECT;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 5'b00000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_money_one    = req_q[0];
  assign out_money_five   = req_q[1];
  assign out_money_ten    = req_q[2];
  assign out_money_twenty = req_q[3];
  assign out_money_fifty  = req_q[4];
  assign remaining        = remaining_q;
  assign note_count       = note_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fault            = fault_q;

endmodule
